// File: rtl/metro_mpi_pkg.sv
// Shared types and sizing for the metro MPI credit link.
// Latency: n/a (types and constants only).
// Backpressure: n/a; CREDIT_WIDTH must satisfy 2**CREDIT_WIDTH > RX_FIFO_DEPTH.
package metro_mpi_pkg;

  // Width of the sender's credit counter; must represent every credit the receiver can hold.
  localparam int CREDIT_WIDTH  = 3;

  // Default receive FIFO depth; at least the sender's reset credit (1).
  localparam int RX_FIFO_DEPTH = 4;

  typedef logic [63:0] link_msg_t;

endpackage

// File: rtl/credit_fifo.sv
// Generic synchronous FIFO with occupancy count; head is read combinationally from storage.
// Latency: a push at edge N is visible at the head after edge N; no write-to-read bypass.
// Backpressure: none internally -- the caller must not push when full unless it also pops.
// Ports: clk_i/rstn_i clock and async active-low reset; push_i/push_dat_i write the tail;
//        pop_i advances the head; head_dat_o, full_o, empty_o, count_o report state.
module credit_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 64,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_dat_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_ptr <= next_ptr(wr_ptr);
      if (pop_i)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only meaningful while non-empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= push_dat_i;
  end

  assign head_dat_o = mem[rd_ptr];
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/credit_receiver.sv
// Credit-link receive endpoint: buffers link beats and returns one yummy credit per drained entry.
// Latency: beat pushed at edge N is on valid_o/data_o after edge N; yummy_o is high the cycle after each pop.
// Backpressure: consumer stalls via ready_i; the link is flow-controlled by credits, a beat arriving when full is dropped and flagged.
// Ports: clk_i/rstn_i clock and async active-low reset; valid_i/data_i link beat in; yummy_o credit return;
//        valid_o/data_o/ready_i consumer handshake (data_o is 0 when empty); overflow_o sticky drop flag;
//        count_o occupancy. Define METRO_RECV_PERF_EN to add recv_count_o and stall_count_o.
module credit_receiver
  import metro_mpi_pkg::*;
#(
  parameter  int DEPTH  = RX_FIFO_DEPTH,
  parameter  int DATA_W = 64,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              yummy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  count_o
`ifdef METRO_RECV_PERF_EN
  ,
  output logic [31:0]       recv_count_o,
  output logic [31:0]       stall_count_o
`endif
);

  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] head_dat;
  logic              yummy_q;
  logic              overflow_q;

  assign pop  = !empty && ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = valid_i && (!full || pop);
  assign drop = valid_i && full && !pop;

  credit_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .push_i     (push),
    .push_dat_i (data_i),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count_o)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yummy_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      yummy_q    <= pop;
      overflow_q <= overflow_q | drop;
    end
  end

  assign yummy_o    = yummy_q;
  assign overflow_o = overflow_q;
  assign valid_o    = !empty;
  assign data_o     = empty ? '0 : head_dat;

`ifdef METRO_RECV_PERF_EN
  logic [31:0] recv_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      recv_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push)              recv_cnt_q  <= recv_cnt_q + 32'd1;
      if (!empty && !ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign recv_count_o  = recv_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // A drop means the sender spent a credit it did not have.
  always @(posedge clk_i) begin
    if (rstn_i) begin
      assert (!drop)
        else $warning("credit_receiver: beat dropped, sender exceeded its credit");
    end
  end
`endif

endmodule

// File: tb/tb_credit_receiver.sv
module tb_credit_receiver;
  import metro_mpi_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              yummy_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              overflow_o;
  logic [CNT_W-1:0]  count_o;
`ifdef METRO_RECV_PERF_EN
  logic [31:0]       recv_count_o;
  logic [31:0]       stall_count_o;
  logic [31:0]       m_recv;
  logic [31:0]       m_stall;
`endif

  always #5 clk_i = ~clk_i;

  credit_receiver #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .yummy_o    (yummy_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o),
    .count_o    (count_o)
`ifdef METRO_RECV_PERF_EN
    ,
    .recv_count_o  (recv_count_o),
    .stall_count_o (stall_count_o)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the FIFO contents as a plain queue plus the two flags.
  link_msg_t mq[$];
  logic      m_yummy;
  logic      m_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_yummy = 1'b0;
    m_ovf   = 1'b0;
`ifdef METRO_RECV_PERF_EN
    m_recv  = '0;
    m_stall = '0;
`endif
  endtask

  task automatic check_outputs(input string tag);
    link_msg_t head;
    head = (mq.size() > 0) ? mq[0] : 64'd0;
    chk({tag, ".count"}, 64'(count_o), 64'(mq.size()));
    chk({tag, ".valid"}, 64'(valid_o), 64'(mq.size() > 0));
    chk({tag, ".data"}, 64'(data_o), head);
    chk({tag, ".yummy"}, 64'(yummy_o), 64'(m_yummy));
    chk({tag, ".ovf"}, 64'(overflow_o), 64'(m_ovf));
`ifdef METRO_RECV_PERF_EN
    chk({tag, ".recv"}, 64'(recv_count_o), 64'(m_recv));
    chk({tag, ".stall"}, 64'(stall_count_o), 64'(m_stall));
`endif
  endtask

  // Drive one cycle, advance the model by the rules, then check after the edge.
  task automatic cycle(input logic v, input link_msg_t d, input logic r, input string tag);
    bit pop;
    bit ok;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    pop = (mq.size() > 0) && r;
    ok  = v && ((mq.size() < DEPTH) || pop);
`ifdef METRO_RECV_PERF_EN
    if (ok) m_recv++;
    if ((mq.size() > 0) && !r) m_stall++;
`endif
    if (v && !ok) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (ok) mq.push_back(d);
    m_yummy = pop;
    @(posedge clk_i);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int credit;
    int beats;
    bit v;
    bit r;
    link_msg_t d;

    rstn_i  = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b0;
    model_reset();
    #13;
    check_outputs("reset");
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Single beat straight through to an always-ready consumer.
    cycle(1'b1, 64'hcafe_cafe_cafe_cafe, 1'b1, "single.push");
    cycle(1'b0, 64'd0, 1'b1, "single.pop");
    cycle(1'b0, 64'd0, 1'b1, "single.idle");

    // Fill with the consumer stalled, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'hA0 + 64'(i), 1'b0, "fill");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 64'd0, 1'b1, "drain");
    cycle(1'b0, 64'd0, 1'b1, "drain.last_yummy");

    // Full with simultaneous push and pop, then a genuine overflow.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'hB0 + 64'(i), 1'b0, "refill");
    cycle(1'b1, 64'hEE, 1'b1, "full_pushpop");
    cycle(1'b1, 64'hDEAD, 1'b0, "overflow");
    cycle(1'b0, 64'd0, 1'b0, "overflow.hold");
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 64'd0, 1'b1, "ovf.drain");

    // Asynchronous reset in the middle of a cycle with three entries held.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'hC0 + 64'(i), 1'b0, "pre_rst");
    valid_i = 1'b0;
    #3;
    rstn_i = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    #1;
    rstn_i = 1'b1;

    // End-to-end with a sender model holding one reset credit.
    credit = 1;
    beats  = 0;
    for (int i = 0; i < 300; i++) begin
      v = (credit > 0) && ($urandom_range(0, 3) != 0);
      r = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      if (v) begin
        credit--;
        beats++;
      end
      cycle(v, d, r, "e2e");
      if (yummy_o) credit++;
    end
    chk("e2e.no_overflow", 64'(overflow_o), 64'd0);
`ifdef METRO_RECV_PERF_EN
    chk("e2e.recv_beats", 64'(recv_count_o), 64'(beats));
`endif

    // Unconstrained traffic, including credit violations.
    for (int i = 0; i < 150; i++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom},
            1'($urandom_range(0, 9) < 3), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
